// File: rtl/uart_pkg.sv
// Shared definitions for the UART register controller: field positions,
// widths and the controller state encoding.
package uart_pkg;

   localparam int ADDR_W        = 7;
   localparam int DATA_W        = 8;
   localparam int CMD_WRITE_BIT = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_WRITE,
      ST_READ,
      ST_READ_CAP,
      ST_TX_START,
      ST_TX_WAIT
   } state_e;

endpackage

// File: rtl/uart_reg_ctrl.sv
// Byte-command register access over a UART: a command byte (bit7 = write) plus a
// data byte for writes; reads return the register value through the transmitter.
// Handshake: a byte is accepted only when uart_rx_valid && uart_rx_en; otherwise it is dropped and counted.
module uart_reg_ctrl
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int ERR_W          = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              uart_rx_valid,
   input  logic [7:0]        uart_rx_data,
   output logic              uart_rx_en,
   output logic              uart_tx_en,
   output logic [7:0]        uart_tx_data,
   input  logic              uart_tx_busy,
   output logic [6:0]        reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic [ERR_W-1:0]  err_count
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                tx_en_q, tx_en_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic                err_inc;

   assign uart_rx_en   = (state_q == ST_IDLE) || (state_q == ST_WAIT_DATA);
   assign reg_we       = (state_q == ST_WRITE);
   assign reg_re       = (state_q == ST_READ);
   assign uart_tx_en   = tx_en_q;
   assign uart_tx_data = tx_data_q;
   assign reg_addr     = addr_q;
   assign reg_wdata    = wdata_q;
   assign err_count    = err_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tx_data_d = tx_data_q;
      tx_en_d   = 1'b0;
      cnt_d     = cnt_q;
      err_inc   = uart_rx_valid && !uart_rx_en;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (uart_rx_valid) begin
               addr_d  = uart_rx_data[ADDR_W-1:0];
               state_d = uart_rx_data[CMD_WRITE_BIT] ? ST_WAIT_DATA : ST_READ;
            end
         end
         ST_WAIT_DATA: begin
            // A data byte on the last allowed cycle still wins over the timeout.
            if (uart_rx_valid) begin
               wdata_d = uart_rx_data;
               state_d = ST_WRITE;
            end else if (cnt_q == CNT_LAST) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WRITE:    state_d = ST_IDLE;
         ST_READ:     state_d = ST_READ_CAP;
         ST_READ_CAP: begin
            tx_data_d = reg_rdata;
            state_d   = ST_TX_START;
         end
         ST_TX_START: begin
            if (!uart_tx_busy) begin
               tx_en_d = 1'b1;
               state_d = ST_TX_WAIT;
            end
         end
         ST_TX_WAIT: begin
            // Busy is ignored in the start-strobe cycle; the transmitter raises it a cycle later.
            if (!tx_en_q && !uart_tx_busy) state_d = ST_IDLE;
         end
         default:     state_d = ST_IDLE;
      endcase

      err_d = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         tx_data_q <= '0;
         tx_en_q   <= 1'b0;
         cnt_q     <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Bench for uart_reg_ctrl: emulates a register bank and a UART transmitter,
// predicts transactions and error counts from the command protocol rules.
module tb_uart_reg_ctrl;

   localparam int T       = 16;
   localparam int ERR_W   = 3;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             uart_rx_valid;
   logic [7:0]       uart_rx_data;
   logic             uart_rx_en;
   logic             uart_tx_en;
   logic [7:0]       uart_tx_data;
   logic             uart_tx_busy;
   logic [6:0]       reg_addr;
   logic [7:0]       reg_wdata;
   logic             reg_we;
   logic             reg_re;
   logic [7:0]       reg_rdata = 8'h00;
   logic [ERR_W-1:0] err_count;

   logic force_busy;
   logic emu_busy = 1'b0;
   assign uart_tx_busy = force_busy | emu_busy;

   uart_reg_ctrl #(.TIMEOUT_CYCLES(T), .ERR_W(ERR_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_en    (uart_rx_en),
      .uart_tx_en    (uart_tx_en),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_busy  (uart_tx_busy),
      .reg_addr      (reg_addr),
      .reg_wdata     (reg_wdata),
      .reg_we        (reg_we),
      .reg_re        (reg_re),
      .reg_rdata     (reg_rdata),
      .err_count     (err_count)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   int exp_err;
   logic [14:0] exp_wr_q[$];
   logic [6:0]  exp_re_q[$];
   logic [7:0]  exp_tx_q[$];
   logic [7:0]  model_mem[128];
   logic [7:0]  bank[128];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- peripheral emulation + monitor ----------------
   int         emu_cnt = 0;
   logic       inflight = 1'b0;
   logic       prev_busy = 1'b0;
   logic       rd_pending = 1'b0;
   logic [7:0] last_tx = 8'h00;

   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) bank[i] = model_mem[i];
         emu_cnt = 0; emu_busy = 1'b0; inflight = 1'b0;
         prev_busy = 1'b0; rd_pending = 1'b0;
      end else begin
         check("we_re_excl", 32'(reg_we & reg_re), 0);
         if (reg_we) begin
            if (exp_wr_q.size() == 0) check("we_unexpected", 32'(reg_we), 0);
            else check("wr_txn", {reg_addr, reg_wdata}, exp_wr_q.pop_front());
            bank[reg_addr] = reg_wdata;
         end
         if (reg_re) begin
            if (exp_re_q.size() == 0) check("re_unexpected", 32'(reg_re), 0);
            else check("rd_addr", reg_addr, exp_re_q.pop_front());
         end
         // Register data is only valid in the cycle after the read strobe.
         reg_rdata  = rd_pending ? bank[reg_addr] : 8'($urandom);
         rd_pending = reg_re;
         if (inflight) begin
            if (prev_busy) begin
               check("txwait_hold", 32'(uart_rx_en), 0);
               check("tx_data_stable", uart_tx_data, last_tx);
            end else begin
               check("txwait_exit", 32'(uart_rx_en), 1);
               inflight = 1'b0;
            end
         end
         if (uart_tx_en) begin
            if (exp_tx_q.size() == 0) check("tx_en_unexpected", 32'(uart_tx_en), 0);
            else begin
               last_tx = exp_tx_q.pop_front();
               check("tx_data", uart_tx_data, last_tx);
            end
            inflight = 1'b1;
            emu_cnt  = $urandom_range(2, 8);
         end else if (emu_cnt > 0) begin
            emu_cnt = emu_cnt - 1;
         end
         emu_busy  = (emu_cnt > 0);
         prev_busy = emu_busy | force_busy;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      uart_rx_valid = 1'b1;
      uart_rx_data  = b;
      @(negedge clk);
      uart_rx_valid = 1'b0;
      uart_rx_data  = 8'($urandom);
   endtask

   task automatic bump_err();
      exp_err = (exp_err == ERR_MAX) ? ERR_MAX : exp_err + 1;
   endtask

   task automatic reset_checks();
      check("rst_we", 32'(reg_we), 0);
      check("rst_re", 32'(reg_re), 0);
      check("rst_tx_en", 32'(uart_tx_en), 0);
      check("rst_addr", reg_addr, 0);
      check("rst_wdata", reg_wdata, 0);
      check("rst_tx_data", uart_tx_data, 0);
      check("rst_err", err_count, 0);
      check("rst_rx_en", 32'(uart_rx_en), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      exp_err = 0;
      exp_wr_q.delete(); exp_re_q.delete(); exp_tx_q.delete();
      reset_checks();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && !uart_rx_en; i++) @(negedge clk);
      check("idle_reached", 32'(uart_rx_en), 1);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int gap, input logic extra_drop);
      send_byte({1'b1, a});
      idle(gap);
      exp_wr_q.push_back({a, d});
      model_mem[a] = d;
      send_byte(d);
      check("we_latency", 32'(reg_we), 1);
      if (extra_drop) begin
         send_byte(8'($urandom));
         bump_err();
      end else begin
         idle(1);
      end
      check("err_after_wr", err_count, exp_err);
   endtask

   task automatic do_read(input logic [6:0] a, input logic drop);
      exp_re_q.push_back(a);
      exp_tx_q.push_back(model_mem[a]);
      send_byte({1'b0, a});
      if (drop) begin
         for (int i = 0; i < 300 && !uart_tx_en; i++) @(negedge clk);
         check("tx_en_seen", 32'(uart_tx_en), 1);
         send_byte(8'($urandom));
         bump_err();
      end
      wait_idle();
      check("err_after_rd", err_count, exp_err);
   endtask

   task automatic do_timeout(input logic [6:0] a);
      send_byte({1'b1, a});
      idle(T - 1);
      check("err_before_to", err_count, exp_err);
      idle(1);
      bump_err();
      check("err_at_to", err_count, exp_err);
      check("rx_en_after_to", 32'(uart_rx_en), 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; uart_rx_valid = 1'b0; uart_rx_data = 8'h00; force_busy = 1'b0;
      exp_err = 0;
      for (int i = 0; i < 128; i++) model_mem[i] = 8'($urandom);
      do_reset();

      // Basic write, then read back through the transmitter.
      do_write(7'h0A, 8'h1F, 3, 1'b0);
      do_write(7'h05, 8'hC3, 0, 1'b0);
      do_read(7'h05, 1'b0);

      // Timeout from a clean error count.
      do_timeout(7'h01);
      check("err_one_timeout", err_count, 1);

      // Transmitter busy for 20 cycles when the read data is ready.
      force_busy = 1'b1;
      exp_re_q.push_back(7'h05);
      exp_tx_q.push_back(model_mem[5]);
      send_byte(8'h05);
      idle(2);
      for (int i = 0; i < 18; i++) begin
         check("tx_en_while_busy", 32'(uart_tx_en), 0);
         @(negedge clk);
      end
      force_busy = 1'b0;
      @(negedge clk);
      check("tx_en_after_busy", 32'(uart_tx_en), 1);
      wait_idle();

      // Byte dropped while the transmitter is sending.
      do_read(7'h0A, 1'b1);
      check("err_after_drop", err_count, 2);

      // Reset in the middle of a write.
      send_byte(8'h83);
      idle(2);
      do_reset();
      do_write(7'h04, 8'h55, 1, 1'b0);
      check("err_after_rst_wr", err_count, 0);

      // Data byte on the very last cycle before timeout is accepted.
      do_write(7'h33, 8'hA5, T - 1, 1'b0);
      check("err_edge_write", err_count, 0);

      for (int n = 0; n < 60; n++) begin
         int         k;
         int         gap;
         logic [6:0] a;
         logic [7:0] d;
         k   = $urandom_range(0, 5);
         a   = 7'($urandom_range(0, 127));
         d   = 8'($urandom);
         gap = ($urandom_range(0, 3) == 0) ? T - 1 : $urandom_range(0, 5);
         case (k)
            0, 1:    do_write(a, d, gap, $urandom_range(0, 3) == 0);
            2, 3:    do_read(a, 1'b0);
            4:       do_read(a, 1'b1);
            default: do_timeout(a);
         endcase
         idle($urandom_range(0, 3));
      end

      // Drive the error counter into saturation.
      for (int n = 0; n < ERR_MAX + 2; n++) do_timeout(7'($urandom_range(0, 127)));
      check("err_saturated", err_count, ERR_MAX);
      do_read(7'h0A, 1'b0);

      idle(4);
      check("wr_q_empty", exp_wr_q.size(), 0);
      check("re_q_empty", exp_re_q.size(), 0);
      check("tx_q_empty", exp_tx_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_reg_ctrl.md
UART_REG_CTRL -- requirements
Module: uart_reg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the maximum clk cycles allowed between the address byte and the data byte of a write.
REQ-002 SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port uart_rx_valid, input, 1, one-cycle strobe marking a received byte on uart_rx_data.
REQ-006 SHALL have port uart_rx_data, input, 8, the received byte; valid only while uart_rx_valid=1.
REQ-007 SHALL have port uart_rx_en, output, 1, high while the block can accept a byte (IDLE, WAIT_DATA).
REQ-008 SHALL have port uart_tx_en, output, 1, one-cycle start strobe to the UART transmitter.
REQ-009 SHALL have port uart_tx_data, output, 8, the byte to transmit; held stable from the uart_tx_en cycle until uart_tx_busy falls.
REQ-010 SHALL have port uart_tx_busy, input, 1, high while the transmitter is sending.
REQ-011 SHALL have port reg_addr, output, 7, the register address.
REQ-012 SHALL have port reg_wdata, output, 8, the write data.
REQ-013 SHALL have port reg_we, output, 1, one-cycle write strobe.
REQ-014 SHALL have port reg_re, output, 1, one-cycle read strobe.
REQ-015 SHALL have port reg_rdata, input, 8, read data, valid exactly one cycle after reg_re.
REQ-016 SHALL have port err_count, output, ERR_W, a saturating count of timeouts plus dropped bytes.

Function
REQ-017 SHALL decode the first byte as a command: bit7=1 write, bit7=0 read; bits[6:0] are the address.
REQ-018 SHALL implement states IDLE, WAIT_DATA, WRITE, READ, READ_CAP, TX_START and TX_WAIT.
REQ-019 SHALL, in IDLE on uart_rx_valid, latch bits[6:0] into reg_addr and go to WAIT_DATA (write) or READ (read).
REQ-020 SHALL, in WAIT_DATA on uart_rx_valid, latch the byte into reg_wdata and go to WRITE.
REQ-021 SHALL assert reg_we for exactly the one WRITE cycle, then return to IDLE; reg_we rises 1 cycle after the data byte strobe.
REQ-022 SHALL assert reg_re for exactly the one READ cycle, then go to READ_CAP.
REQ-023 SHALL, in READ_CAP, capture reg_rdata into uart_tx_data and go to TX_START.
REQ-024 SHALL, in TX_START, wait while uart_tx_busy=1, then pulse uart_tx_en for one cycle and go to TX_WAIT.
REQ-025 SHALL, in TX_WAIT, return to IDLE on the first cycle in which uart_tx_busy=0 at least 1 cycle after uart_tx_en.
REQ-026 SHALL count clk cycles in WAIT_DATA, with the counter cleared on entry.
REQ-027 SHALL, when that count reaches TIMEOUT_CYCLES-1 with no byte, return to IDLE, produce no reg_we and increment err_count.
REQ-028 SHALL give a byte arriving in the same cycle as the timeout priority: the write completes and there is no error.
REQ-029 SHALL drop any uart_rx_valid that arrives while uart_rx_en=0, increment err_count and leave the state unchanged.
REQ-030 SHALL saturate err_count at all-ones with no wrap.
REQ-031 SHALL never assert reg_we and reg_re in the same cycle.
REQ-032 SHALL keep reg_addr and reg_wdata held between transactions.

Reset
REQ-033 SHALL, on reset=1 at a clk edge, set: state IDLE; reg_we, reg_re and uart_tx_en 0; reg_addr, reg_wdata, uart_tx_data and err_count 0; timeout counter 0; uart_rx_en 1 on the first cycle after reset releases.
REQ-034 SHALL make reset mid-transaction abandon it with no strobe emitted, and SHALL not count that as an error.

Structure
REQ-035 SHALL place the state encoding, the CMD_WRITE_BIT index (7) and the ADDR_W=7 and DATA_W=8 widths in shared package uart_pkg.
REQ-036 SHALL be a single module with no sub-modules; the timeout counter is sized $clog2(TIMEOUT_CYCLES).

Verification
REQ-037 SHALL cover write: bytes 8'h8A then 8'h1F -> one reg_we pulse with reg_addr=7'h0A and reg_wdata=8'h1F, 1 cycle after the second strobe.
REQ-038 SHALL cover read: byte 8'h05 with reg_rdata=8'hC3 -> reg_re with reg_addr=7'h05, then uart_tx_en with uart_tx_data=8'hC3.
REQ-039 SHALL cover timeout: byte 8'h81 followed by no byte for TIMEOUT_CYCLES cycles -> back to IDLE, no reg_we, err_count=1.
REQ-040 SHALL cover dropped byte: a byte sent while in TX_WAIT (uart_tx_busy=1) -> err_count increments and the read completes normally.
REQ-041 SHALL cover busy transmitter: uart_tx_busy=1 held for 20 cycles at READ_CAP -> uart_tx_en fires 1 cycle after busy falls.
REQ-042 SHALL cover reset mid-write: reset after 8'h83 -> no reg_we, err_count=0, and the next write 8'h84/8'h55 succeeds.
